// File: rtl/eaglesong_coeff_sequencer.sv
// Streams Eaglesong rotation coefficient pairs (c1,c2) per state word, round after round,
// LANES words per beat, with ready/valid flow control, abort and a completion pulse.
module eaglesong_coeff_sequencer #(
  parameter int NUM_WORDS = 16,
  parameter int COEFF_W   = 5,
  parameter int LANES     = 1,
  parameter int ROUND_W   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROUND_W-1:0]            rounds_req,
  input  logic                          abort,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*COEFF_W-1:0]      out_c1,
  output logic [LANES*COEFF_W-1:0]      out_c2,
  output logic [$clog2(NUM_WORDS)-1:0]  out_word,
  output logic [ROUND_W-1:0]            out_round,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int WORD_W = $clog2(NUM_WORDS);
  localparam logic ONE_BEAT_ROUND = (NUM_WORDS == LANES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [ROUND_W-1:0] rounds_lat;
  logic               wrap;
  logic [WORD_W-1:0]  nxt_word;
  logic [ROUND_W-1:0] nxt_round;
  logic               nxt_last;

  function automatic logic [COEFF_W-1:0] c1_of(input int idx);
    logic [4:0] v;
    v = '0;
    case (idx % 16)
      0: v = 5'd2;   1: v = 5'd13;  2: v = 5'd4;   3: v = 5'd3;
      4: v = 5'd27;  5: v = 5'd3;   6: v = 5'd17;  7: v = 5'd3;
      8: v = 5'd18;  9: v = 5'd12; 10: v = 5'd4;  11: v = 5'd4;
     12: v = 5'd12; 13: v = 5'd7;  14: v = 5'd7;  15: v = 5'd1;
      default: v = '0;
    endcase
    return COEFF_W'(v);
  endfunction

  function automatic logic [COEFF_W-1:0] c2_of(input int idx);
    logic [4:0] v;
    v = '0;
    case (idx % 16)
      0: v = 5'd4;   1: v = 5'd22;  2: v = 5'd19;  3: v = 5'd14;
      4: v = 5'd31;  5: v = 5'd8;   6: v = 5'd26;  7: v = 5'd12;
      8: v = 5'd22;  9: v = 5'd18; 10: v = 5'd7;  11: v = 5'd31;
     12: v = 5'd27; 13: v = 5'd17; 14: v = 5'd8;  15: v = 5'd13;
      default: v = '0;
    endcase
    return COEFF_W'(v);
  endfunction

  function automatic logic [LANES*COEFF_W-1:0] pack_c1(input logic [WORD_W-1:0] base);
    logic [LANES*COEFF_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*COEFF_W +: COEFF_W] = c1_of(int'(base) + k);
    return r;
  endfunction

  function automatic logic [LANES*COEFF_W-1:0] pack_c2(input logic [WORD_W-1:0] base);
    logic [LANES*COEFF_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*COEFF_W +: COEFF_W] = c2_of(int'(base) + k);
    return r;
  endfunction

  // Position of the beat that follows the one currently presented.
  always_comb begin
    wrap      = (out_word == WORD_W'(NUM_WORDS - LANES));
    nxt_word  = wrap ? '0 : out_word + WORD_W'(LANES);
    nxt_round = wrap ? out_round + ROUND_W'(1) : out_round;
    nxt_last  = (nxt_round == rounds_lat - ROUND_W'(1)) &&
                (nxt_word == WORD_W'(NUM_WORDS - LANES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rounds_lat <= '0;
      out_valid  <= 1'b0;
      out_c1     <= '0;
      out_c2     <= '0;
      out_word   <= '0;
      out_round  <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (rounds_req != '0) begin
                state      <= RUN;
                rounds_lat <= rounds_req;
                out_word   <= '0;
                out_round  <= '0;
                out_c1     <= pack_c1('0);
                out_c2     <= pack_c2('0);
                out_last   <= (rounds_req == ROUND_W'(1)) && ONE_BEAT_ROUND;
                out_valid  <= 1'b1;
                busy       <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RUN: begin
            if (out_ready) begin
              if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                out_word  <= nxt_word;
                out_round <= nxt_round;
                out_c1    <= pack_c1(nxt_word);
                out_c2    <= pack_c2(nxt_word);
                out_last  <= nxt_last;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
